dcache_flush_ctrl: RTL and testbench
====================================

// Module: dcache_flush_ctrl
// PURPOSE
//  Sequencer and port-owner for the 4-way D-cache state array (dsram, {dirty,valid} per way).
//  On a flush request it walks every set and every way, issues a write-back request for each
//  dirty+valid line, then clears the state entry to 2'b00.
//  When idle it passes the CPU-side cache controller's state-array accesses straight through.
//  While busy it owns the port and stalls the CPU side.
// PARAMETERS
//  AW   `D_INDEX_WIDTH  log2(number of cache sets)
//  DW   2               state width; bit1 = dirty, bit0 = valid (fixed encoding)
//  NUM  (1<<AW)         number of sets walked per flush
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst_n       in   1   asynchronous, active-low reset
//  flush_req   in   1   start flush; sampled only in IDLE
//  flush_busy  out  1   high in every state except IDLE
//  flush_done  out  1   one-cycle pulse when the walk completes
//  cpu_index   in   AW  CPU-side set index
//  cpu_way     in   2   CPU-side way select
//  cpu_din     in   DW  CPU-side write data
//  cpu_we      in   1   CPU-side write enable
//  cpu_en      in   1   CPU-side enable
//  cpu_stall   out  1   = flush_busy; CPU-side access is not performed
//  ds_index    out  AW  to dsram index
//  ds_way      out  2   to dsram way
//  ds_din      out  DW  to dsram din
//  ds_we       out  1   to dsram we
//  ds_en       out  1   to dsram en
//  ds_dout0-3  in   DW  from dsram (combinational read of ds_index)
//  wb_req      out  1   write-back request; held until wb_ack
//  wb_index    out  AW  set of the line to write back
//  wb_way      out  2   way of the line to write back
//  wb_ack      in   1   write-back accepted (sampled while wb_req=1)
// BEHAVIOUR
//  Reset values
//   - state=IDLE; idx=0; way=0; snap=0.
//   - flush_busy=0, flush_done=0, wb_req=0.
//   - ds_* follow cpu_* (IDLE passthrough).
//  IDLE
//   - ds_*=cpu_* combinationally.
//   - flush_req=1 -> idx<=0, go RD.
//   - A CPU access in the same cycle as flush_req is still performed.
//  RD
//   - ds_en=1, ds_we=0, ds_index=idx.
//   - snap[way k]<=ds_doutk; way<=0; go CHK.
//  CHK
//   - snap[way]==2'b11 -> go WB.
//   - Otherwise -> go CLR (invalid or clean lines need no write-back).
//  WB
//   - wb_req=1, wb_index=idx, wb_way=way, held stable while wb_ack=0.
//   - wb_ack=1 -> go CLR; wb_req is low in the following cycle.
//   - wb_ack while wb_req=0 is ignored.
//  CLR
//   - ds_en=1, ds_we=1, ds_index=idx, ds_way=way, ds_din=2'b00.
//   - way<3 -> way++, go CHK.
//   - way==3 and idx<NUM-1 -> idx++, go RD.
//   - way==3 and idx==NUM-1 -> go DONE.
//  DONE
//   - flush_done=1 for exactly one cycle (flush_busy still 1); go IDLE.
//  Sequencing and timing
//   - Outside IDLE: ds_we=0 and ds_en=0 except in RD and CLR; cpu_* are ignored.
//   - Ways are processed in order 0..3; sets in order 0..NUM-1.
//   - idx is AW bits wide; the last-set test is on idx==NUM-1, never on overflow.
//   - Clean set costs 9 cycles (RD + 4x CHK/CLR).
//   - All-clean cache: flush_req to flush_done = 9*NUM+1 cycles.
//   - Each dirty line adds 1 + (cycles until wb_ack) cycles.
//  Boundary conditions
//   - flush_req while busy is ignored; no queuing.
//   - rst_n low mid-flush: immediate return to IDLE.
//     wb_req, flush_busy and ds_we drop asynchronously; no partial clear is completed.
//   - wb_ack arriving in the same cycle wb_req first rises completes the handshake in one cycle.
// TESTING
//  1. AW=2, all entries 00; flush_req pulse -> no wb_req; 4 clears/set; flush_done at cycle 37; no ds writes after.
//  2. Set1 way2=11, wb_ack 3 cycles later -> wb_req held 3 cycles with wb_index=1, wb_way=2; then mem1/way2=00.
//  3. Set0 ways0,3=11; way1=01; way2=10 -> exactly 2 wb_req (way0, way3); all four ways 00 afterwards.
//  4. IDLE, cpu_we=1 index=3 way=1 din=11 with flush_req same cycle -> CPU write lands; flush then writes it back.
//  5. During flush: cpu_we=1 and second flush_req -> cpu_stall=1, no CPU write, single flush_done.
//  6. rst_n low while wb_req=1 -> wb_req=0 and flush_busy=0 same cycle; state IDLE; later flush restarts at idx 0.

Source files
------------

// File: rtl/dcache_flush_ctrl.sv
// Flush sequencer and port owner for the 4-way D-cache state array.
// IDLE passes CPU accesses through; a flush walks every set/way, writes back dirty lines, clears state.
`ifndef D_INDEX_WIDTH
`define D_INDEX_WIDTH 2
`endif

module dcache_flush_ctrl #(
  parameter int AW = `D_INDEX_WIDTH,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          flush_done,
  input  logic [AW-1:0] cpu_index,
  input  logic [1:0]    cpu_way,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  input  logic          cpu_en,
  output logic          cpu_stall,
  output logic [AW-1:0] ds_index,
  output logic [1:0]    ds_way,
  output logic [DW-1:0] ds_din,
  output logic          ds_we,
  output logic          ds_en,
  input  logic [DW-1:0] ds_dout0,
  input  logic [DW-1:0] ds_dout1,
  input  logic [DW-1:0] ds_dout2,
  input  logic [DW-1:0] ds_dout3,
  output logic          wb_req,
  output logic [AW-1:0] wb_index,
  output logic [1:0]    wb_way,
  input  logic          wb_ack,
  output logic [2:0]    dbg_state
);

  localparam int NUM = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM - 1);
  localparam logic [DW-1:0] DIRTY_VALID = DW'(2'b11);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_WB   = 3'd3,
    S_CLR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                 state, state_nxt;
  logic [AW-1:0]          idx, idx_nxt;
  logic [1:0]             way, way_nxt;
  logic [3:0][DW-1:0]     snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      way   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      way   <= way_nxt;
      // One read captures all four ways of the set; CHK then walks the snapshot.
      if (state == S_RD) snap <= {ds_dout3, ds_dout2, ds_dout1, ds_dout0};
    end
  end

  // Handshake: wb_req rises in WB and holds wb_index/wb_way stable until a cycle with wb_ack=1;
  // that cycle completes the transfer, and wb_ack in any other cycle has no effect.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    way_nxt    = way;
    ds_index   = idx;
    ds_way     = way;
    ds_din     = '0;
    ds_we      = 1'b0;
    ds_en      = 1'b0;
    wb_req     = 1'b0;
    flush_done = 1'b0;
    case (state)
      S_IDLE: begin
        ds_index = cpu_index;
        ds_way   = cpu_way;
        ds_din   = cpu_din;
        ds_we    = cpu_we;
        ds_en    = cpu_en;
        if (flush_req) begin
          idx_nxt   = '0;
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        ds_en     = 1'b1;
        way_nxt   = '0;
        state_nxt = S_CHK;
      end
      S_CHK: begin
        state_nxt = (snap[way] == DIRTY_VALID) ? S_WB : S_CLR;
      end
      S_WB: begin
        wb_req = 1'b1;
        if (wb_ack) state_nxt = S_CLR;
      end
      S_CLR: begin
        ds_en = 1'b1;
        ds_we = 1'b1;
        if (way != 2'd3) begin
          way_nxt   = way + 2'd1;
          state_nxt = S_CHK;
        end else if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_RD;
        end
      end
      S_DONE: begin
        flush_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign flush_busy = (state != S_IDLE);
  assign cpu_stall  = flush_busy;
  assign wb_index   = idx;
  assign wb_way     = way;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Randomized bench for dcache_flush_ctrl: state-array model, write-back responder,
// expected write-back queue with a decoupled monitor, latency and clear checks.
module tb_dcache_flush_ctrl;
  localparam int AW  = 2;
  localparam int NUM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_req;
  logic          flush_busy, flush_done, cpu_stall;
  logic [AW-1:0] cpu_index, ds_index, wb_index;
  logic [1:0]    cpu_way, ds_way, wb_way;
  logic [1:0]    cpu_din, ds_din;
  logic          cpu_we, cpu_en, ds_we, ds_en;
  logic [1:0]    ds_dout0, ds_dout1, ds_dout2, ds_dout3;
  logic          wb_req, wb_ack;
  logic [2:0]    dbg_state;

  dcache_flush_ctrl #(.AW(AW), .DW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_busy(flush_busy),
    .flush_done(flush_done), .cpu_index(cpu_index), .cpu_way(cpu_way), .cpu_din(cpu_din),
    .cpu_we(cpu_we), .cpu_en(cpu_en), .cpu_stall(cpu_stall), .ds_index(ds_index),
    .ds_way(ds_way), .ds_din(ds_din), .ds_we(ds_we), .ds_en(ds_en),
    .ds_dout0(ds_dout0), .ds_dout1(ds_dout1), .ds_dout2(ds_dout2), .ds_dout3(ds_dout3),
    .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way), .wb_ack(wb_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- state-array model ----------------
  logic [1:0] mem [NUM][4];
  assign ds_dout0 = mem[ds_index][0];
  assign ds_dout1 = mem[ds_index][1];
  assign ds_dout2 = mem[ds_index][2];
  assign ds_dout3 = mem[ds_index][3];
  always @(posedge clk) if (ds_en && ds_we) mem[ds_index][ds_way] = ds_din;

  // ---------------- scoreboard ----------------
  logic [AW+1:0] exp_q[$];
  int            delay_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- write-back responder ----------------
  bit in_wb = 0;
  int cur_d = 0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      wb_ack = 1'b0;
      in_wb  = 0;
    end else if (wb_req) begin
      if (!in_wb) begin
        in_wb    = 1;
        wait_cnt = 0;
        cur_d    = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
      end
      wb_ack = (wait_cnt == cur_d);
      wait_cnt++;
    end else begin
      in_wb  = 0;
      wb_ack = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
    end
  end

  // ---------------- monitor ----------------
  bit            prev_req = 0;
  logic [AW+1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 0;
    end else begin
      if (wb_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", int'({wb_index, wb_way}), -1);
        end else begin
          chk("wb_line", int'({wb_index, wb_way}), int'(exp_q.pop_front()));
        end
        held = {wb_index, wb_way};
      end else if (wb_req) begin
        chk("wb_hold", int'({wb_index, wb_way}), int'(held));
      end
      prev_req = wb_req;
      if (flush_done) begin
        done_cnt++;
        chk("done_busy", int'(flush_busy), 1);
      end
      if (flush_busy) chk("cpu_stall", int'(cpu_stall), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_idle();
    cpu_en = 0; cpu_we = 0; cpu_index = '0; cpu_way = '0; cpu_din = '0;
  endtask

  task automatic fill(input int mode);  // 0: zero, 1: random
    for (int s = 0; s < NUM; s++)
      for (int w = 0; w < 4; w++)
        mem[s][w] = (mode == 0) ? 2'b00 : 2'($urandom_range(0, 3));
  endtask

  task automatic do_flush(input bit cpu_wr, input int wr_idx, input int wr_way,
                          input int fixed_d, input bit noisy);
    logic [1:0] r [NUM][4];
    int exp_lat, lat, d, done_before, nz;
    for (int s = 0; s < NUM; s++)
      for (int w = 0; w < 4; w++) r[s][w] = mem[s][w];
    if (cpu_wr) r[wr_idx][wr_way] = 2'b11;
    exp_lat = 9 * NUM + 1;
    for (int s = 0; s < NUM; s++)
      for (int w = 0; w < 4; w++)
        if (r[s][w] == 2'b11) begin
          exp_q.push_back({2'(s), 2'(w)});
          d = (fixed_d >= 0) ? fixed_d : $urandom_range(0, 3);
          delay_q.push_back(d);
          exp_lat += 1 + d;
        end
    done_before = done_cnt;
    flush_req = 1;
    if (cpu_wr) begin
      cpu_en = 1; cpu_we = 1; cpu_index = AW'(wr_idx); cpu_way = 2'(wr_way); cpu_din = 2'b11;
    end else cpu_idle();
    @(negedge clk);
    lat = 1;
    while (!flush_done && lat < 500) begin
      if (noisy) begin
        flush_req = 1'($urandom_range(0, 1));
        cpu_en = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_din = 2'b11;
        cpu_index = AW'($urandom_range(0, NUM - 1)); cpu_way = 2'($urandom_range(0, 3));
      end else begin
        flush_req = 0;
        cpu_idle();
      end
      @(negedge clk);
      lat++;
    end
    flush_req = 0;
    cpu_idle();
    chk("flush_latency", lat, exp_lat);
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt - done_before, 1);
    chk("busy_after", int'(flush_busy), 0);
    chk("ds_we_after", int'(ds_we), 0);
    chk("exp_q_left", exp_q.size(), 0);
    nz = 0;
    for (int s = 0; s < NUM; s++)
      for (int w = 0; w < 4; w++) if (mem[s][w] != 2'b00) nz++;
    chk("mem_cleared", nz, 0);
    exp_q.delete();
    delay_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst_n = 0; flush_req = 0; cpu_idle(); wb_ack = 0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(flush_busy), 0);
    chk("rst_done", int'(flush_done), 0);
    chk("rst_wb_req", int'(wb_req), 0);
    chk("rst_state", int'(dbg_state), 0);
    rst_n = 1;
    @(negedge clk);

    // Idle passthrough
    for (int i = 0; i < 8; i++) begin
      cpu_en = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
      cpu_index = AW'($urandom_range(0, NUM - 1)); cpu_way = 2'($urandom_range(0, 3));
      cpu_din = 2'($urandom_range(0, 3));
      #1;
      chk("passthru", int'({ds_index, ds_way, ds_din, ds_we, ds_en}),
          int'({cpu_index, cpu_way, cpu_din, cpu_we, cpu_en}));
      @(negedge clk);
    end
    cpu_idle();

    // All clean
    fill(0);
    do_flush(0, 0, 0, -1, 0);
    // Single dirty line, ack after 3 cycles of wb_req
    fill(0); mem[1][2] = 2'b11;
    do_flush(0, 0, 0, 2, 0);
    // Mixed states in set 0
    fill(0); mem[0][0] = 2'b11; mem[0][1] = 2'b01; mem[0][2] = 2'b10; mem[0][3] = 2'b11;
    do_flush(0, 0, 0, -1, 0);
    // CPU write in the flush_req cycle
    fill(0);
    do_flush(1, 3, 1, 0, 0);
    // CPU traffic and repeated flush_req while busy
    fill(1);
    do_flush(0, 0, 0, -1, 1);
    // Random contents
    for (int i = 0; i < 6; i++) begin
      fill(1);
      do_flush(($urandom_range(0, 1) == 1), $urandom_range(0, NUM - 1), $urandom_range(0, 3),
               -1, ($urandom_range(0, 1) == 1));
    end

    // Reset while a write-back is pending
    fill(0); mem[2][1] = 2'b11;
    exp_q.push_back({2'd2, 2'd1});
    delay_q.push_back(50);
    flush_req = 1;
    @(negedge clk);
    flush_req = 0;
    guard = 0;
    while (!wb_req && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("wb_seen", int'(wb_req), 1);
    rst_n = 0;
    #1;
    chk("arst_wb_req", int'(wb_req), 0);
    chk("arst_busy", int'(flush_busy), 0);
    chk("arst_ds_we", int'(ds_we), 0);
    chk("arst_state", int'(dbg_state), 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    delay_q.delete();
    rst_n = 1;
    @(negedge clk);
    chk("no_partial_clr", int'(mem[2][1]), 3);
    mem[0][0] = 2'b11;
    do_flush(0, 0, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
